// File: rtl/fp_arbiter.sv
// Two-requester round-robin front end for one shared fp_unit.
// Optional WAIT-state abort is built only when FP_ARBITER_TIMEOUT_EN is defined.
module fp_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0][95:0]  req_data,
  input  logic [1:0][16:0]  req_ctrl,
  output logic [1:0]        rsp_valid,
  output logic [31:0]       rsp_result,
  output logic [4:0]        rsp_flags,
  output logic              rsp_timeout,
  output logic              fpu_enable,
  output logic [95:0]       fpu_data,
  output logic [16:0]       fpu_ctrl,
  input  logic [31:0]       fpu_result,
  input  logic [4:0]        fpu_flags,
  input  logic              fpu_ready,
  output logic [1:0]        state_dbg
);

  // Handshake: a request transfers on a rising edge where req_valid[i] & req_ready[i];
  // ready is offered only in IDLE, only to the granted requester. Responses are
  // single-cycle pulses on rsp_valid with no backpressure.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   owner;
  logic   grant_idx;
  logic   grant_vld;
  logic   transfer;
  logic   timed_out;

  // Tie goes to the requester that was not served last.
  always_comb begin
    grant_vld = |req_valid;
    grant_idx = req_valid[1];
    if (&req_valid) grant_idx = ~last_grant;
  end

  assign transfer   = (state == IDLE) && grant_vld;
  assign req_ready  = (transfer && reset) ? (2'b01 << grant_idx) : 2'b00;
  assign rsp_valid  = (state == RESP) ? (2'b01 << owner) : 2'b00;
  assign fpu_enable = (state == ISSUE);
  assign state_dbg  = state;

`ifdef FP_ARBITER_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        rsp_timeout_q;

  assign timed_out   = (wait_cnt == 16'(TIMEOUT - 1));
  assign rsp_timeout = rsp_timeout_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_cnt      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;
      // fpu_ready wins over a coincident timeout.
      if (state == WAIT && fpu_ready) rsp_timeout_q <= 1'b0;
      else if (state == WAIT && timed_out) rsp_timeout_q <= 1'b1;
    end
  end
`else
  assign timed_out   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (fpu_ready || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      fpu_data   <= '0;
      fpu_ctrl   <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      state <= state_nxt;
      if (transfer) begin
        fpu_data   <= req_data[grant_idx];
        fpu_ctrl   <= req_ctrl[grant_idx];
        owner      <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == WAIT && fpu_ready) begin
        rsp_result <= fpu_result;
        rsp_flags  <= fpu_flags;
      end else if (state == WAIT && timed_out) begin
        // Abort payload: canonical quiet NaN with the invalid flag.
        rsp_result <= 32'h7FC0_0000;
        rsp_flags  <= 5'b10000;
      end
    end
  end

endmodule

// File: tb/tb_fp_arbiter.sv
// Directed bench for fp_arbiter; the timeout scenario is compiled in only
// when FP_ARBITER_TIMEOUT_EN is defined.
module tb_fp_arbiter;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][95:0]  req_data;
  logic [1:0][16:0]  req_ctrl;
  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_result;
  logic [4:0]        rsp_flags;
  logic              rsp_timeout;
  logic              fpu_enable;
  logic [95:0]       fpu_data;
  logic [16:0]       fpu_ctrl;
  logic [31:0]       fpu_result;
  logic [4:0]        fpu_flags;
  logic              fpu_ready;
  logic [1:0]        state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  logic [1:0] exp_q[$];

  fp_arbiter #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_timeout(rsp_timeout),
    .fpu_enable(fpu_enable), .fpu_data(fpu_data), .fpu_ctrl(fpu_ctrl),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_ready(fpu_ready),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    req_valid  = 2'b00;
    fpu_ready  = 1'b0;
    fpu_result = '0;
    fpu_flags  = '0;
    cycle();
    cycle();
    reset = 1'b1;
    #1;
  endtask

  // Drives one operation from the IDLE cycle in which the grant is visible
  // through RESP, returning in the following IDLE cycle.
  task automatic run_op(input logic [1:0] grant, input logic [95:0] exp_data,
                        input logic [16:0] exp_ctrl, input int wait_cyc,
                        input logic [31:0] res, input logic [4:0] flg,
                        input bit raise0, input bit ready_in_issue);
    logic [1:0] exp_rsp;
    #1;
    check("grant", req_ready, grant);
    exp_q.push_back(grant);
    cycle();
    check("issue_en", fpu_enable, 1'b1);
    check("issue_data", fpu_data, exp_data);
    check("issue_ctrl", fpu_ctrl, exp_ctrl);
    check("issue_ready", req_ready, 2'b00);
    if (ready_in_issue) begin
      fpu_ready  = 1'b1;
      fpu_result = 32'hDEAD_BEEF;
      fpu_flags  = 5'b11111;
    end
    cycle();
    fpu_ready = 1'b0;
    if (raise0) req_valid[0] = 1'b1;
    #1;
    check("wait_en", fpu_enable, 1'b0);
    for (int i = 0; i < wait_cyc; i++) begin
      check("wait_state", state_dbg, 2'd2);
      check("wait_ready", req_ready, 2'b00);
      check("wait_rsp", rsp_valid, 2'b00);
      cycle();
    end
    fpu_ready  = 1'b1;
    fpu_result = res;
    fpu_flags  = flg;
    cycle();
    fpu_ready  = 1'b0;
    fpu_result = 32'h1234_5678;
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1'b1, 1'b0);
      exp_rsp = 2'b00;
    end else begin
      exp_rsp = exp_q.pop_front();
    end
    check("rsp_valid", rsp_valid, exp_rsp);
    check("rsp_result", rsp_result, res);
    check("rsp_flags", rsp_flags, flg);
    check("rsp_timeout", rsp_timeout, 1'b0);
    check("rsp_ready", req_ready, 2'b00);
    cycle();
    check("idle_rsp", rsp_valid, 2'b00);
    check("hold_data", fpu_data, exp_data);
  endtask

  initial begin
    req_data = '0;
    req_ctrl = '0;
    do_reset();

    // Reset state
    check("rst_ready", req_ready, 2'b00);
    check("rst_rsp", rsp_valid, 2'b00);
    check("rst_result", rsp_result, 32'h0);
    check("rst_flags", rsp_flags, 5'h0);
    check("rst_timeout", rsp_timeout, 1'b0);
    check("rst_en", fpu_enable, 1'b0);
    check("rst_data", fpu_data, 96'h0);
    check("rst_ctrl", fpu_ctrl, 17'h0);
    check("rst_state", state_dbg, 2'd0);

    // fadd 1.0 + 2.0 = 3.0 from requester 0
    req_data[0] = {32'h3F80_0000, 32'h4000_0000, 32'h0};
    req_ctrl[0] = {2'b00, 3'b000, 2'b00, 10'h001};
    req_valid   = 2'b01;
    run_op(2'b01, {32'h3F80_0000, 32'h4000_0000, 32'h0}, {2'b00, 3'b000, 2'b00, 10'h001},
           0, 32'h4040_0000, 5'h0, 1'b0, 1'b0);
    req_valid = 2'b00;

    // Both valid after reset: strict alternation starting at requester 0
    do_reset();
    req_data[0] = {32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003};
    req_ctrl[0] = {2'b01, 3'b001, 2'b00, 10'h010};
    req_data[1] = {32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003};
    req_ctrl[1] = {2'b10, 3'b011, 2'b01, 10'h020};
    req_valid   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        run_op(2'b01, {32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003},
               {2'b01, 3'b001, 2'b00, 10'h010}, k, 32'h0100_0000 + k, 5'(k), 1'b0, 1'b0);
      else
        run_op(2'b10, {32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003},
               {2'b10, 3'b011, 2'b01, 10'h020}, k, 32'h0200_0000 + k, 5'(k), 1'b0, 1'b0);
    end
    req_valid = 2'b00;

    // req1 fdiv; req0 raised during WAIT is served right after
    req_data[1] = {32'h4120_0000, 32'h4000_0000, 32'h0};
    req_ctrl[1] = {2'b00, 3'b000, 2'b00, 10'h004};
    req_valid   = 2'b10;
    run_op(2'b10, {32'h4120_0000, 32'h4000_0000, 32'h0}, {2'b00, 3'b000, 2'b00, 10'h004},
           2, 32'h40A0_0000, 5'h0, 1'b1, 1'b0);
    req_valid = 2'b01;
    run_op(2'b01, {32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003},
           {2'b01, 3'b001, 2'b00, 10'h010}, 1, 32'h3F00_0000, 5'b00001, 1'b0, 1'b0);
    req_valid = 2'b00;

    // fpu_ready during ISSUE is ignored
    req_valid = 2'b10;
    run_op(2'b10, {32'h4120_0000, 32'h4000_0000, 32'h0}, {2'b00, 3'b000, 2'b00, 10'h004},
           3, 32'h4110_0000, 5'b00100, 1'b0, 1'b1);
    req_valid = 2'b00;

`ifdef FP_ARBITER_TIMEOUT_EN
    // Abort after TIMEOUT=8 cycles in WAIT
    req_valid = 2'b01;
    #1;
    check("to_grant", req_ready, 2'b01);
    cycle();
    req_valid = 2'b00;
    cycle();
    for (int i = 0; i < 8; i++) begin
      check("to_wait", rsp_valid, 2'b00);
      cycle();
    end
    check("to_rsp", rsp_valid, 2'b01);
    check("to_result", rsp_result, 32'h7FC0_0000);
    check("to_flags", rsp_flags, 5'b10000);
    check("to_flag", rsp_timeout, 1'b1);
    cycle();
    // A normal op afterwards clears the timeout indication
    req_valid = 2'b01;
    run_op(2'b01, {32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003},
           {2'b01, 3'b001, 2'b00, 10'h010}, 0, 32'h4000_0000, 5'h0, 1'b0, 1'b0);
    req_valid = 2'b00;
`endif

    // Reset during WAIT abandons the op; a late fpu_ready does nothing
    req_valid = 2'b01;
    cycle();
    req_valid = 2'b00;
    cycle();
    #1;
    check("pre_rst_state", state_dbg, 2'd2);
    reset = 1'b0;
    cycle();
    reset      = 1'b1;
    fpu_ready  = 1'b1;
    fpu_result = 32'h4040_0000;
    fpu_flags  = 5'b00011;
    cycle();
    fpu_ready = 1'b0;
    #1;
    check("late_rsp", rsp_valid, 2'b00);
    check("late_state", state_dbg, 2'd0);
    check("late_result", rsp_result, 32'h0);
    check("late_flags", rsp_flags, 5'h0);
    check("late_en", fpu_enable, 1'b0);
    check("late_data", fpu_data, 96'h0);
    check("late_ctrl", fpu_ctrl, 17'h0);
    check("late_ready", req_ready, 2'b00);
    cycle();
    check("late_rsp2", rsp_valid, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
